unidad_control_multiciclo: RTL and testbench

- Multicycle control FSM for the MIPS datapath; successor to the single-cycle control unit.
- Sequences each instruction through fetch, decode, execute, memory and writeback over several clock cycles.
- Drives the shared-memory, ALU-mux, PC and register-file enables.
- Stalls on a memory ready handshake and counts retired instructions.

---
 rtl/unidad_control_pkg.sv | 42 ++++
 rtl/decodificador_estado.sv | 105 ++++++++++
 rtl/unidad_control_multiciclo.sv | 99 +++++++++
 tb/tb_unidad_control_multiciclo.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/unidad_control_pkg.sv
// Shared types and constants for the multicycle MIPS control unit:
// state encodings, opcodes and datapath mux selects.
package unidad_control_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXEC_R    = 4'd7,
    R_WB      = 4'd8,
    BRANCH    = 4'd9,
    EXEC_I    = 4'd10,
    I_WB      = 4'd11,
    JUMP      = 4'd12,
    ILLEGAL   = 4'd13
  } stateT;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/decodificador_estado.sv
// Moore decode of the control state into datapath controls; only the
// FETCH-cycle IR/PC loads and the SW retire depend on MemReady.
module decodificador_estado
  import unidad_control_pkg::*;
(
  input  logic [3:0] State,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemToWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic       Retired
);

  stateT st;
  assign st = stateT'(State);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemToWrite = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemToReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_RT;
    ALUOp      = ALU_ADD;
    PCSource   = PCSRC_ALU;
    Illegal    = 1'b0;
    Retired    = 1'b0;
    case (st)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE:   ALUSrcB = SRCB_IMM_SH2;
      MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEM_WB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
        Retired  = 1'b1;
      end
      MEM_WRITE: begin
        MemToWrite = 1'b1;
        IorD       = 1'b1;
        Retired    = MemReady;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALU_FUNCT;
      end
      R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        Retired  = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = ALU_SUB;
        Branch   = 1'b1;
        PCSource = PCSRC_ALUOUT;
        Retired  = 1'b1;
      end
      EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      I_WB: begin
        RegWrite = 1'b1;
        Retired  = 1'b1;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        Retired  = 1'b1;
      end
      ILLEGAL: Illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/unidad_control_multiciclo.sv
// Multicycle MIPS control unit: state register, opcode capture, sequencing
// and retired-instruction counter around the state decoder.
module unidad_control_multiciclo
  import unidad_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Enable,
  input  logic [5:0]       OpCode,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             Branch,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemToWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             Illegal,
  output logic             Retired,
  output logic [CNT_W-1:0] InstrCount,
  output logic [3:0]       State
);

  stateT      state;
  stateT      nextState;
  stateT      boundary;
  logic [5:0] opReg;

  assign State    = state;
  assign boundary = Enable ? FETCH : IDLE;

  decodificador_estado uDecoder (
    .State      (state),
    .MemReady   (MemReady),
    .PCWrite    (PCWrite),
    .Branch     (Branch),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemToWrite (MemToWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemToReg   (MemToReg),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .Illegal    (Illegal),
    .Retired    (Retired)
  );

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     if (Enable) nextState = FETCH;
      FETCH:    if (MemReady) nextState = DECODE;
      DECODE: begin
        case (OpCode)
          OP_RTYPE:     nextState = EXEC_R;
          OP_LW, OP_SW: nextState = MEM_ADDR;
          OP_BEQ:       nextState = BRANCH;
          OP_ADDI:      nextState = EXEC_I;
          OP_J:         nextState = JUMP;
          default:      nextState = ILLEGAL;
        endcase
      end
      // The live OpCode may already belong to the next fetch; use the capture.
      MEM_ADDR:  nextState = (opReg == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (MemReady) nextState = MEM_WB;
      MEM_WRITE: if (MemReady) nextState = boundary;
      EXEC_R:    nextState = R_WB;
      EXEC_I:    nextState = I_WB;
      MEM_WB, R_WB, BRANCH, I_WB, JUMP, ILLEGAL: nextState = boundary;
      default:   nextState = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      opReg      <= '0;
      InstrCount <= '0;
    end else begin
      state <= nextState;
      if (state == DECODE) opReg <= OpCode;
      if (Retired) InstrCount <= InstrCount + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed bench for unidad_control_multiciclo: walks every instruction class
// cycle by cycle, plus stalls, Enable drop, mid-instruction reset and counter wrap.
module tb_unidad_control_multiciclo;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEM_ADDR = 3, S_MEM_READ = 4;
  localparam int S_MEM_WB = 5, S_MEM_WRITE = 6, S_EXEC_R = 7, S_R_WB = 8, S_BRANCH = 9;
  localparam int S_EXEC_I = 10, S_I_WB = 11, S_JUMP = 12, S_ILLEGAL = 13;

  logic       clk = 1'b0;
  logic       reset, Enable, MemReady;
  logic [5:0] OpCode;

  logic        PCWrite, Branch, IorD, MemRead, MemToWrite, IRWrite, RegDst, MemToReg;
  logic        RegWrite, ALUSrcA, Illegal, Retired;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic [31:0] InstrCount;
  logic [3:0]  State;
  logic [18:0] ctrl;

  // Second instance with a 2-bit counter so the wrap is reachable by running.
  logic [18:0] smallCtrl;
  logic [1:0]  smallCount;
  logic [3:0]  smallState;

  int          nVec = 0;
  int          nMis = 0;
  logic [31:0] expCnt;

  always #5 clk = ~clk;

  assign ctrl = {PCWrite, Branch, IorD, MemRead, MemToWrite, IRWrite, RegDst, MemToReg,
                 RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal, Retired};

  unidad_control_multiciclo dut (
    .clk(clk), .reset(reset), .Enable(Enable), .OpCode(OpCode), .MemReady(MemReady),
    .PCWrite(PCWrite), .Branch(Branch), .IorD(IorD), .MemRead(MemRead),
    .MemToWrite(MemToWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .Illegal(Illegal), .Retired(Retired),
    .InstrCount(InstrCount), .State(State)
  );

  unidad_control_multiciclo #(.CNT_W(2)) dutSmall (
    .clk(clk), .reset(reset), .Enable(Enable), .OpCode(OpCode), .MemReady(MemReady),
    .PCWrite(smallCtrl[18]), .Branch(smallCtrl[17]), .IorD(smallCtrl[16]),
    .MemRead(smallCtrl[15]), .MemToWrite(smallCtrl[14]), .IRWrite(smallCtrl[13]),
    .RegDst(smallCtrl[12]), .MemToReg(smallCtrl[11]), .RegWrite(smallCtrl[10]),
    .ALUSrcA(smallCtrl[9]), .ALUSrcB(smallCtrl[8:7]), .ALUOp(smallCtrl[6:4]),
    .PCSource(smallCtrl[3:2]), .Illegal(smallCtrl[1]), .Retired(smallCtrl[0]),
    .InstrCount(smallCount), .State(smallState)
  );

  // Expected control vector per state, in the same bit order as ctrl.
  function automatic logic [18:0] expCtrl(input int s, input logic mr);
    logic pcw, br, iord, mrd, mwr, irw, rdst, m2r, rw, srca, ill, ret;
    logic [1:0] srcb, pcs;
    logic [2:0] aop;
    {pcw, br, iord, mrd, mwr, irw, rdst, m2r, rw, srca, ill, ret} = '0;
    srcb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (s)
      S_FETCH:     begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      S_DECODE:    srcb = 2'b11;
      S_MEM_ADDR:  begin srca = 1; srcb = 2'b10; end
      S_MEM_READ:  begin mrd = 1; iord = 1; end
      S_MEM_WB:    begin m2r = 1; rw = 1; ret = 1; end
      S_MEM_WRITE: begin mwr = 1; iord = 1; ret = mr; end
      S_EXEC_R:    begin srca = 1; aop = 3'b010; end
      S_R_WB:      begin rdst = 1; rw = 1; ret = 1; end
      S_BRANCH:    begin srca = 1; aop = 3'b001; br = 1; pcs = 2'b01; ret = 1; end
      S_EXEC_I:    begin srca = 1; srcb = 2'b10; end
      S_I_WB:      begin rw = 1; ret = 1; end
      S_JUMP:      begin pcw = 1; pcs = 2'b10; ret = 1; end
      S_ILLEGAL:   ill = 1;
      default:     ;
    endcase
    return {pcw, br, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aop, pcs, ill, ret};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Check one cycle in state s against the table, then advance one clock.
  task automatic st(input string tag, input int s);
    logic [18:0] e;
    e = expCtrl(s, MemReady);
    #1;
    check({tag, "/state"},  State,      s);
    check({tag, "/ctrl"},   ctrl,       e);
    check({tag, "/count"},  InstrCount, expCnt);
    check({tag, "/sState"}, smallState, s);
    check({tag, "/sCtrl"},  smallCtrl,  e);
    check({tag, "/sCount"}, smallCount, expCnt[1:0]);
    tick();
    if (e[0]) expCnt = expCnt + 1;
  endtask

  initial begin
    reset = 1'b1; Enable = 1'b0; OpCode = 6'b000000; MemReady = 1'b1; expCnt = '0;
    tick(); tick();
    st("reset", S_IDLE);
    reset = 1'b0;
    st("idle_hold", S_IDLE);

    // R-type: 4 cycles, one retire.
    Enable = 1'b1; OpCode = 6'b000000;
    st("r", S_IDLE); st("r", S_FETCH); st("r", S_DECODE); st("r", S_EXEC_R); st("r", S_R_WB);
    check("r_count", InstrCount, 32'd1);

    // LW with two stall cycles in MEM_READ; live OpCode switched to SW after DECODE.
    OpCode = 6'b100011;
    st("lw", S_FETCH); st("lw", S_DECODE);
    OpCode = 6'b101011;
    st("lw", S_MEM_ADDR);
    MemReady = 1'b0;
    st("lw_stall", S_MEM_READ); st("lw_stall", S_MEM_READ);
    MemReady = 1'b1;
    st("lw", S_MEM_READ); st("lw", S_MEM_WB);

    // SW with a FETCH stall and a MEM_WRITE stall; live OpCode switched to LW.
    MemReady = 1'b0;
    st("sw_fstall", S_FETCH);
    MemReady = 1'b1;
    st("sw", S_FETCH); st("sw", S_DECODE);
    OpCode = 6'b100011;
    st("sw", S_MEM_ADDR);
    MemReady = 1'b0;
    st("sw_stall", S_MEM_WRITE);
    MemReady = 1'b1;
    st("sw", S_MEM_WRITE);

    OpCode = 6'b000100;
    st("beq", S_FETCH); st("beq", S_DECODE); st("beq", S_BRANCH);
    check("beq_count", InstrCount, 32'd4);

    OpCode = 6'b111111;
    st("ill", S_FETCH); st("ill", S_DECODE); st("ill", S_ILLEGAL);
    check("ill_count", InstrCount, 32'd4);

    // ADDI with Enable dropped in EXEC_I: finishes, then parks in IDLE.
    OpCode = 6'b001000;
    st("addi", S_FETCH); st("addi", S_DECODE); st("addi", S_EXEC_I);
    Enable = 1'b0;
    st("addi", S_I_WB); st("addi_idle", S_IDLE); st("addi_idle", S_IDLE);

    Enable = 1'b1; OpCode = 6'b000010;
    st("j", S_IDLE); st("j", S_FETCH); st("j", S_DECODE); st("j", S_JUMP);
    check("pre_reset_count", InstrCount, 32'd6);
    check("pre_reset_scount", smallCount, 2'd2);

    // Reset asserted while LW waits in MEM_READ.
    OpCode = 6'b100011;
    st("lw2", S_FETCH); st("lw2", S_DECODE); st("lw2", S_MEM_ADDR);
    MemReady = 1'b0;
    #1;
    check("lw2/in_mem_read", State, S_MEM_READ);
    reset = 1'b1;
    #1;
    check("async_rst/state", State, S_IDLE);
    check("async_rst/ctrl", ctrl, 19'd0);
    check("async_rst/count", InstrCount, 32'd0);
    check("async_rst/scount", smallCount, 2'd0);
    expCnt = '0;
    st("rst_hold", S_IDLE);
    reset = 1'b0; MemReady = 1'b1; OpCode = 6'b000010;

    // Four jumps: the 2-bit counter reaches all-ones and then wraps to 0.
    st("wrap", S_IDLE);
    for (int i = 0; i < 4; i++) begin
      st("wrap_j", S_FETCH); st("wrap_j", S_DECODE); st("wrap_j", S_JUMP);
      if (i == 2) check("wrap_allones", smallCount, 2'd3);
    end
    check("wrap_zero", smallCount, 2'd0);
    check("wrap_main", InstrCount, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
